wbm_desc_fetch: RTL and testbench

- Wishbone master that fetches one 16-byte scatter-gather descriptor (four 32-bit words) from system memory when the DMA control logic requests it.
- Returns the next pointer, buffer address, descriptor control and state fields as one atomically updated set.
- Acts as the initiating end of the Wishbone bus, opposite our slave register block.
- Handles ack, err and rty responses, with a bounded retry count.

---
 rtl/wbm_desc_fetch_if.sv | 24 ++
 rtl/wbm_desc_fetch.sv | 181 ++++++++++++++++++
 tb/tb_wbm_desc_fetch.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbm_desc_fetch_if.sv
// Wishbone master-side bus bundle used by the descriptor fetcher.
// Signal names keep the master's point of view (_o driven by master, _i driven by slave).
interface wbm_desc_fetch_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_cab_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wbm_desc_fetch.sv
// Wishbone master fetching a 4-word scatter-gather descriptor with bounded retry.
// Optional response timeout enabled by defining WBM_FETCH_TIMEOUT_EN.
module wbm_desc_fetch #(
    parameter int unsigned RTY_MAX = 8
`ifdef WBM_FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             fetch_req,
    input  logic [31:3]      fetch_adr,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             fetch_err,
    output logic [1:0]       err_code,
    output logic [31:3]      desc_next,
    output logic [31:3]      desc_addr,
    output logic [15:0]      desc_ctrl,
    output logic [7:0]       desc_state,
    wbm_desc_fetch_if.master wbm
);

    typedef enum logic [2:0] {StIdle, StBus, StBackoff, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:3] base_q, base_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  rty_q, rty_d;
    logic [7:0]  rty_inc;
    logic [1:0]  err_q, err_d;
    logic [31:3] w0_q, w0_d;
    logic [31:3] w1_q, w1_d;
    logic [15:0] w2_q, w2_d;
    logic [31:3] next_q, next_d;
    logic [31:3] addr_q, addr_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic [7:0]  dstate_q, dstate_d;
    logic        in_bus;
`ifdef WBM_FETCH_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;
`endif

    assign rty_inc = rty_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        idx_d    = idx_q;
        rty_d    = rty_q;
        err_d    = err_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        next_d   = next_q;
        addr_d   = addr_q;
        ctrl_d   = ctrl_q;
        dstate_d = dstate_q;
`ifdef WBM_FETCH_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        case (state_q)
            StIdle: begin
                if (fetch_req) begin
                    base_d  = fetch_adr;
                    idx_d   = 2'd0;
                    rty_d   = 8'd0;
                    err_d   = 2'b00;
                    state_d = StBus;
`ifdef WBM_FETCH_TIMEOUT_EN
                    wait_d  = 16'd0;
`endif
                end
            end
            StBus: begin
                if (wbm.wbm_err_i) begin
                    err_d   = 2'b01;
                    state_d = StErr;
                end else if (wbm.wbm_rty_i) begin
                    rty_d = rty_inc;
                    if (rty_inc == 8'(RTY_MAX)) begin
                        err_d   = 2'b10;
                        state_d = StErr;
                    end else begin
                        state_d = StBackoff;
                    end
                end else if (wbm.wbm_ack_i) begin
                    idx_d = idx_q + 2'd1;
`ifdef WBM_FETCH_TIMEOUT_EN
                    wait_d = 16'd0;
`endif
                    unique case (idx_q)
                        2'd0: w0_d = wbm.wbm_dat_i[31:3];
                        2'd1: w1_d = wbm.wbm_dat_i[31:3];
                        2'd2: w2_d = wbm.wbm_dat_i[15:0];
                        2'd3: begin
                            // Last word goes straight to the outputs so all fields move together.
                            next_d   = w0_q;
                            addr_d   = w1_q;
                            ctrl_d   = w2_q;
                            dstate_d = wbm.wbm_dat_i[7:0];
                            state_d  = StDone;
                        end
                    endcase
`ifdef WBM_FETCH_TIMEOUT_EN
                end else if (wait_q == 16'(TIMEOUT_CYC - 1)) begin
                    err_d   = 2'b11;
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 16'd1;
`endif
                end
            end
            StBackoff: begin
                state_d = StBus;
`ifdef WBM_FETCH_TIMEOUT_EN
                wait_d  = 16'd0;
`endif
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            base_q   <= '0;
            idx_q    <= '0;
            rty_q    <= '0;
            err_q    <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            next_q   <= '0;
            addr_q   <= '0;
            ctrl_q   <= '0;
            dstate_q <= '0;
`ifdef WBM_FETCH_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            rty_q    <= rty_d;
            err_q    <= err_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            next_q   <= next_d;
            addr_q   <= addr_d;
            ctrl_q   <= ctrl_d;
            dstate_q <= dstate_d;
`ifdef WBM_FETCH_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    // Bus outputs decode straight from state so reset drops cyc/stb without waiting for a clock.
    assign in_bus        = (state_q == StBus);
    assign wbm.wbm_cyc_o = in_bus;
    assign wbm.wbm_stb_o = in_bus;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_sel_o = in_bus ? 4'hf : 4'h0;
    assign wbm.wbm_cab_o = in_bus && (idx_q != 2'd3);
    assign wbm.wbm_adr_o = in_bus ? ({base_q, 3'b000} + {28'd0, idx_q, 2'b00}) : 32'd0;

    assign fetch_busy = in_bus || (state_q == StBackoff);
    assign fetch_done = (state_q == StDone);
    assign fetch_err  = (state_q == StErr);
    assign err_code   = err_q;
    assign desc_next  = next_q;
    assign desc_addr  = addr_q;
    assign desc_ctrl  = ctrl_q;
    assign desc_state = dstate_q;

endmodule

// File: tb/tb_wbm_desc_fetch.sv
// Directed self-checking bench for wbm_desc_fetch with a scripted Wishbone slave.
module tb_wbm_desc_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:3] fetch_adr;
    logic        fetch_busy, fetch_done, fetch_err;
    logic [1:0]  err_code;
    logic [31:3] desc_next, desc_addr;
    logic [15:0] desc_ctrl;
    logic [7:0]  desc_state;

    wbm_desc_fetch_if bus ();

`ifdef WBM_FETCH_TIMEOUT_EN
    wbm_desc_fetch #(.RTY_MAX(8), .TIMEOUT_CYC(16)) dut (
`else
    wbm_desc_fetch #(.RTY_MAX(8)) dut (
`endif
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .fetch_req (fetch_req),
        .fetch_adr (fetch_adr),
        .fetch_busy(fetch_busy),
        .fetch_done(fetch_done),
        .fetch_err (fetch_err),
        .err_code  (err_code),
        .desc_next (desc_next),
        .desc_addr (desc_addr),
        .desc_ctrl (desc_ctrl),
        .desc_state(desc_state),
        .wbm       (bus.master)
    );

    int checks = 0;
    int failures = 0;

    // Slave scripting knobs and access log.
    logic [31:0] mem [4];
    logic [31:0] cur_base;
    int          silent_word = -1;
    int          err_word = -1;
    int          rty_word = -1;
    int          rty_left = 0;
    bit          rty_all = 0;
    logic [31:0] adr_log [$];
    bit          cab_log [$];
    int          gap_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : slave
        int w;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_rty_i = 1'b0;
        bus.wbm_dat_i = 32'd0;
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            adr_log.push_back(bus.wbm_adr_o);
            cab_log.push_back(bus.wbm_cab_o);
            w = int'((bus.wbm_adr_o - cur_base) >> 2) & 3;
            if (rty_all) begin
                bus.wbm_rty_i = 1'b1;
            end else if (w == err_word) begin
                bus.wbm_err_i = 1'b1;
                bus.wbm_ack_i = 1'b1;
                bus.wbm_dat_i = mem[w];
            end else if (w == silent_word) begin
                bus.wbm_ack_i = 1'b0;
            end else if (w == rty_word && rty_left > 0) begin
                bus.wbm_rty_i = 1'b1;
                rty_left--;
            end else begin
                bus.wbm_ack_i = 1'b1;
                bus.wbm_dat_i = mem[w];
            end
        end else if (fetch_busy) begin
            gap_cnt++;
        end
    end

    // Cycle 1 is the request cycle; returns the cycle on which done/err was first seen.
    task automatic run_fetch(input logic [31:0] base, output int cyc, output bit done,
                             output bit errf);
        adr_log.delete();
        cab_log.delete();
        gap_cnt  = 0;
        cur_base = base;
        done     = 1'b0;
        errf     = 1'b0;
        @(negedge clk);
        fetch_adr = base[31:3];
        fetch_req = 1'b1;
        cyc = 1;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) fetch_req = 1'b0;
            cyc++;
            if (fetch_done || fetch_err) begin
                done = fetch_done;
                errf = fetch_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({fetch_busy, fetch_done, fetch_err, err_code, desc_next, desc_addr, desc_ctrl,
             desc_state} !== '0) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b err=%b code=%b next=%h", fetch_busy,
                     fetch_done, fetch_err, err_code, desc_next);
        end
        checks++;
        if ({bus.wbm_adr_o, bus.wbm_sel_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
             bus.wbm_cab_o} !== '0) begin
            failures++;
            $display("FAIL reset_bus got adr=%h sel=%h cyc=%b stb=%b we=%b cab=%b expected all 0",
                     bus.wbm_adr_o, bus.wbm_sel_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                     bus.wbm_cab_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        bit done, errf;
        logic [31:0] exp_adr [4];
        bit exp_cab [4];
        exp_adr = '{32'h1000_0008, 32'h1000_000C, 32'h1000_0010, 32'h1000_0014};
        exp_cab = '{1'b1, 1'b1, 1'b1, 1'b0};
        mem = '{32'h2000_0010, 32'h3000_0000, 32'h0000_ABCD, 32'h0000_0042};
        run_fetch(32'h1000_0008, cyc, done, errf);
        checks++;
        if (!done || errf || cyc != 6) begin
            failures++;
            $display("FAIL basic_latency got done=%b err=%b cycle=%0d expected done at 6", done,
                     errf, cyc);
        end
        checks++;
        if (adr_log.size() != 4) begin
            failures++;
            $display("FAIL basic_nacc got %0d accesses expected 4", adr_log.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (adr_log[k] !== exp_adr[k] || cab_log[k] !== exp_cab[k]) begin
                failures++;
                $display("FAIL basic_adr%0d got %h cab=%b expected %h cab=%b", k, adr_log[k],
                         cab_log[k], exp_adr[k], exp_cab[k]);
            end
        end
        checks++;
        if (desc_next !== 29'h0400_0002 || desc_addr !== 29'h0600_0000 || desc_ctrl !== 16'hABCD
            || desc_state !== 8'h42 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL basic_desc got next=%h addr=%h ctrl=%h state=%h code=%b", desc_next,
                     desc_addr, desc_ctrl, desc_state, err_code);
        end
    endtask

    task automatic test_retry();
        int cyc;
        bit done, errf;
        logic [31:0] exp_adr [6];
        exp_adr = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h10C};
        mem = '{32'h1234_5678, 32'h8765_4320, 32'hFFFF_1111, 32'h0000_00A5};
        rty_word = 2;
        rty_left = 2;
        run_fetch(32'h0000_0100, cyc, done, errf);
        rty_word = -1;
        checks++;
        if (!done || errf || cyc != 10 || gap_cnt != 2) begin
            failures++;
            $display("FAIL retry_flow got done=%b err=%b cycle=%0d gaps=%0d expected 1 0 10 2",
                     done, errf, cyc, gap_cnt);
        end
        checks++;
        if (adr_log.size() != 6) begin
            failures++;
            $display("FAIL retry_nacc got %0d expected 6", adr_log.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (adr_log[k] !== exp_adr[k]) begin
                failures++;
                $display("FAIL retry_adr%0d got %h expected %h", k, adr_log[k], exp_adr[k]);
            end
        end
        checks++;
        if (desc_next !== 29'h0246_8ACF || desc_addr !== 29'h10EC_A864 || desc_ctrl !== 16'h1111
            || desc_state !== 8'hA5 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL retry_desc got next=%h addr=%h ctrl=%h state=%h code=%b", desc_next,
                     desc_addr, desc_ctrl, desc_state, err_code);
        end
    endtask

    task automatic test_rty_limit();
        int cyc;
        bit done, errf;
        rty_all = 1'b1;
        run_fetch(32'h0000_0200, cyc, done, errf);
        rty_all = 1'b0;
        checks++;
        if (done || !errf || cyc != 17 || err_code !== 2'b10) begin
            failures++;
            $display("FAIL rtylim_flow got done=%b err=%b cycle=%0d code=%b expected 0 1 17 10",
                     done, errf, cyc, err_code);
        end
        checks++;
        if (adr_log.size() != 8 || gap_cnt != 7) begin
            failures++;
            $display("FAIL rtylim_count got acc=%0d gaps=%0d expected 8 7", adr_log.size(),
                     gap_cnt);
        end
        checks++;
        if (desc_next !== 29'h0246_8ACF || desc_addr !== 29'h10EC_A864 || desc_ctrl !== 16'h1111
            || desc_state !== 8'hA5) begin
            failures++;
            $display("FAIL rtylim_hold got next=%h addr=%h ctrl=%h state=%h", desc_next,
                     desc_addr, desc_ctrl, desc_state);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_code !== 2'b10 || fetch_err !== 1'b0 || fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL rtylim_after got code=%b err=%b busy=%b expected 10 0 0", err_code,
                     fetch_err, fetch_busy);
        end
    endtask

    task automatic test_err_ack();
        int cyc;
        bit done, errf;
        mem = '{32'hCAFE_0008, 32'hBEEF_0010, 32'h0000_5A5A, 32'h0000_0007};
        err_word = 1;
        run_fetch(32'h0000_0300, cyc, done, errf);
        err_word = -1;
        checks++;
        if (done || !errf || cyc != 4 || err_code !== 2'b01 || bus.wbm_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL errack_flow got done=%b err=%b cycle=%0d code=%b cyc=%b", done, errf,
                     cyc, err_code, bus.wbm_cyc_o);
        end
        checks++;
        if (adr_log.size() != 2 || desc_ctrl !== 16'h1111) begin
            failures++;
            $display("FAIL errack_hold got acc=%0d ctrl=%h expected 2 1111", adr_log.size(),
                     desc_ctrl);
        end
        run_fetch(32'h0000_0300, cyc, done, errf);
        checks++;
        if (!done || cyc != 6 || err_code !== 2'b00 || desc_next !== 29'h195F_C001 ||
            desc_addr !== 29'h17DD_E002 || desc_ctrl !== 16'h5A5A || desc_state !== 8'h07) begin
            failures++;
            $display("FAIL errack_recover got done=%b cycle=%0d code=%b next=%h addr=%h ctrl=%h",
                     done, cyc, err_code, desc_next, desc_addr, desc_ctrl);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit done, errf;
        logic [31:0] exp_adr [4];
        exp_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        run_fetch(32'hFFFF_FFF8, cyc, done, errf);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (adr_log[k] !== exp_adr[k]) begin
                failures++;
                $display("FAIL wrap_adr%0d got %h expected %h", k, adr_log[k], exp_adr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, first, second;
        adr_log.delete();
        cur_base = 32'h0000_0400;
        first = 0;
        second = 0;
        @(negedge clk);
        fetch_adr = 29'h0000_0080;
        fetch_req = 1'b1;
        n = 1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n == 3) fetch_adr = 29'h0000_1000;
            if (n == 5) fetch_adr = 29'h0000_0080;
            if (fetch_done) begin
                if (first == 0) first = n;
                else begin
                    second = n;
                    break;
                end
            end
        end
        fetch_req = 1'b0;
        checks++;
        if (first != 6 || second != 12) begin
            failures++;
            $display("FAIL b2b_timing got first=%0d second=%0d expected 6 12", first, second);
        end
        checks++;
        if (adr_log.size() != 8 || adr_log[2] !== 32'h0000_0408 || adr_log[4] !== 32'h0000_0400)
        begin
            failures++;
            $display("FAIL b2b_adr got n=%0d adr2=%h adr4=%h expected 8 408 400", adr_log.size(),
                     adr_log[2], adr_log[4]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (fetch_busy !== 1'b0 || bus.wbm_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_noqueue got busy=%b cyc=%b expected 0 0", fetch_busy,
                     bus.wbm_cyc_o);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        adr_log.delete();
        cur_base = 32'h0000_0500;
        silent_word = 2;
        hit = 1'b0;
        @(negedge clk);
        fetch_adr = 29'h0000_00A0;
        fetch_req = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            fetch_req = 1'b0;
            if (bus.wbm_adr_o === 32'h0000_0508 && bus.wbm_cyc_o === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_reach got idx2=%b expected 1", hit);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop got cyc=%b stb=%b busy=%b expected 0 0 0", bus.wbm_cyc_o,
                     bus.wbm_stb_o, fetch_busy);
        end
        checks++;
        if ({desc_next, desc_addr, desc_ctrl, desc_state, err_code} !== '0) begin
            failures++;
            $display("FAIL rstmid_desc got next=%h addr=%h ctrl=%h state=%h code=%b", desc_next,
                     desc_addr, desc_ctrl, desc_state, err_code);
        end
        silent_word = -1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fetch_busy !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || fetch_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got busy=%b cyc=%b done=%b expected 0 0 0", fetch_busy,
                     bus.wbm_cyc_o, fetch_done);
        end
    endtask

`ifdef WBM_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit done, errf;
        silent_word = 0;
        run_fetch(32'h0000_0600, cyc, done, errf);
        silent_word = -1;
        checks++;
        if (done || !errf || cyc != 18 || err_code !== 2'b11) begin
            failures++;
            $display("FAIL timeout got done=%b err=%b cycle=%0d code=%b expected 0 1 18 11", done,
                     errf, cyc, err_code);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0;
        fetch_adr = '0;
        cur_base = 32'd0;
        mem = '{32'd0, 32'd0, 32'd0, 32'd0};
        test_reset();
        test_basic();
        test_retry();
        test_rty_limit();
        test_err_ack();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef WBM_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
